// File: rtl/ctrl_sequencer.sv
// Control-word sequencer: replays a host-loaded program store onto the ctrl bus
// over valid/ready. Optional multi-pass replay is enabled by CTRL_SEQ_REPEAT_EN.
module ctrl_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [6:0]    ld_data,
  input  logic [AW:0]   len,
  input  logic [7:0]    rep_cnt,
  input  logic          start,
  input  logic          abort,
  output logic [6:0]    ctrl,
  output logic          ctrl_valid,
  input  logic          ctrl_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  logic [6:0]    mem [DEPTH];
  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [6:0]    ctrl_q, ctrl_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW:0]   len_eff;
  logic          last_word;
  logic          more_passes;

`ifdef CTRL_SEQ_REPEAT_EN
  logic [7:0]    pass_q, pass_d;
  assign more_passes = (pass_q > 8'd1);
`else
  logic          unused_rep;
  assign unused_rep  = ^rep_cnt;
  assign more_passes = 1'b0;
`endif

  assign len_eff   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
  assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  // Store is writable only while idle and not being started in the same cycle.
  always_ff @(posedge clk) begin
    if (ld_en && state_q == S_IDLE && !start)
      mem[ld_addr] <= ld_data;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef CTRL_SEQ_REPEAT_EN
    pass_d  = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d  = len_eff;
          pc_d   = '0;
          busy_d = 1'b1;
`ifdef CTRL_SEQ_REPEAT_EN
          pass_d = (rep_cnt == 8'd0) ? 8'd1 : rep_cnt;
`endif
          if (len_eff == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            ctrl_d  = mem[0];
            valid_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        // Abort beats a coincident handshake: that word is treated as unconsumed.
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (valid_q && ctrl_ready) begin
          if (!last_word) begin
            pc_d   = pc_q + 1'b1;
            ctrl_d = mem[pc_q + 1'b1];
          end else if (more_passes) begin
            pc_d   = '0;
            ctrl_d = mem[0];
`ifdef CTRL_SEQ_REPEAT_EN
            pass_d = pass_q - 8'd1;
`endif
          end else begin
            state_d = S_FIN;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CTRL_SEQ_REPEAT_EN
      pass_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CTRL_SEQ_REPEAT_EN
      pass_q  <= pass_d;
`endif
    end
  end

  assign ctrl       = ctrl_q;
  assign ctrl_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle vector table plus multi-cycle sequences.
module tb_ctrl_sequencer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NV    = 34;

  logic          clk = 1'b0;
  logic          rst_n, ld_en, start, abort, ctrl_ready;
  logic [AW-1:0] ld_addr;
  logic [6:0]    ld_data;
  logic [AW:0]   len;
  logic [7:0]    rep_cnt;
  logic [6:0]    ctrl;
  logic          ctrl_valid, busy, done;

  int errors = 0;
  int checks = 0;

  ctrl_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .len(len), .rep_cnt(rep_cnt), .start(start), .abort(abort), .ctrl(ctrl),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, ld_en;
    logic [3:0] addr;
    logic [6:0] data;
    logic [4:0] len;
    logic       start, abort, rdy;
    logic [6:0] e_ctrl;
    logic       e_valid, e_busy, e_done;
  } vec_t;

  vec_t vt [NV];
  logic [6:0] words [$];
  logic [6:0] pat;

  function automatic vec_t v(logic r, logic l, logic [3:0] a, logic [6:0] d, logic [4:0] n,
                             logic s, logic ab, logic rd,
                             logic [6:0] ec, logic ev, logic eb, logic ed);
    vec_t x;
    x.rst_n = r; x.ld_en = l; x.addr = a; x.data = d; x.len = n;
    x.start = s; x.abort = ab; x.rdy = rd;
    x.e_ctrl = ec; x.e_valid = ev; x.e_busy = eb; x.e_done = ed;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [6:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Start a run with ready held high and collect every word presented until done.
  task automatic run_collect(input logic [4:0] n, input logic [7:0] rep, output logic bubble);
    logic got_done;
    words.delete();
    bubble = 1'b0;
    got_done = 1'b0;
    len = n; rep_cnt = rep; ctrl_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (ctrl_valid) words.push_back(ctrl);
      else if (!done) bubble = 1'b1;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tick();
    end
    chk("run_done_seen", {31'b0, got_done}, 32'd1);
    tick();
  endtask

  initial begin
    logic bub;
    int exp_n;
    rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; len = '0; rep_cnt = '0;
    start = 1'b0; abort = 1'b0; ctrl_ready = 1'b0;

    vt[0]  = v(0,0,0,7'h00,0, 0,0,0, 7'h00,0,0,0);
    vt[1]  = v(1,1,0,7'h51,0, 0,0,0, 7'h00,0,0,0);
    vt[2]  = v(1,1,1,7'h2C,0, 0,0,0, 7'h00,0,0,0);
    vt[3]  = v(1,1,2,7'h03,0, 0,0,0, 7'h00,0,0,0);
    vt[4]  = v(1,0,0,7'h00,3, 1,0,1, 7'h51,1,1,0);
    vt[5]  = v(1,0,0,7'h00,3, 0,0,1, 7'h2C,1,1,0);
    vt[6]  = v(1,0,0,7'h00,3, 0,0,1, 7'h03,1,1,0);
    vt[7]  = v(1,0,0,7'h00,3, 0,0,1, 7'h03,0,1,1);
    vt[8]  = v(1,0,0,7'h00,3, 0,0,0, 7'h03,0,0,0);
    vt[9]  = v(1,0,0,7'h00,3, 1,0,0, 7'h51,1,1,0);
    vt[10] = v(1,0,0,7'h00,3, 0,0,1, 7'h2C,1,1,0);
    vt[11] = v(1,0,0,7'h00,3, 0,0,0, 7'h2C,1,1,0);
    vt[12] = v(1,0,0,7'h00,3, 0,0,0, 7'h2C,1,1,0);
    vt[13] = v(1,0,0,7'h00,3, 0,0,1, 7'h03,1,1,0);
    vt[14] = v(1,0,0,7'h00,3, 0,0,1, 7'h03,0,1,1);
    vt[15] = v(1,0,0,7'h00,3, 0,0,0, 7'h03,0,0,0);
    vt[16] = v(1,0,0,7'h00,0, 1,0,1, 7'h03,0,1,1);
    vt[17] = v(1,0,0,7'h00,0, 0,0,1, 7'h03,0,0,0);
    vt[18] = v(1,0,0,7'h00,3, 1,0,1, 7'h51,1,1,0);
    vt[19] = v(1,1,1,7'h7F,3, 0,0,1, 7'h2C,1,1,0);
    vt[20] = v(1,0,0,7'h00,3, 0,1,1, 7'h2C,0,0,0);
    vt[21] = v(1,0,0,7'h00,3, 0,0,1, 7'h2C,0,0,0);
    vt[22] = v(1,0,0,7'h00,3, 1,0,1, 7'h51,1,1,0);
    vt[23] = v(1,0,0,7'h00,3, 0,0,1, 7'h2C,1,1,0);
    vt[24] = v(1,0,0,7'h00,3, 0,0,1, 7'h03,1,1,0);
    vt[25] = v(1,0,0,7'h00,3, 0,0,1, 7'h03,0,1,1);
    vt[26] = v(1,0,0,7'h00,3, 0,0,0, 7'h03,0,0,0);
    vt[27] = v(1,0,0,7'h00,3, 1,1,1, 7'h03,0,0,0);
    vt[28] = v(1,1,0,7'h11,1, 1,0,0, 7'h51,1,1,0);
    vt[29] = v(1,0,0,7'h00,1, 0,0,1, 7'h51,0,1,1);
    vt[30] = v(1,0,0,7'h00,1, 0,0,0, 7'h51,0,0,0);
    vt[31] = v(1,0,0,7'h00,1, 1,0,1, 7'h51,1,1,0);
    vt[32] = v(1,0,0,7'h00,1, 0,0,1, 7'h51,0,1,1);
    vt[33] = v(1,0,0,7'h00,1, 1,1,1, 7'h51,0,0,0);

    #2;
    for (int i = 0; i < NV; i++) begin
      rst_n = vt[i].rst_n; ld_en = vt[i].ld_en; ld_addr = vt[i].addr; ld_data = vt[i].data;
      len = vt[i].len; start = vt[i].start; abort = vt[i].abort; ctrl_ready = vt[i].rdy;
      rep_cnt = 8'd1;
      tick();
      chk($sformatf("v%0d.ctrl", i),  {25'b0, ctrl},       {25'b0, vt[i].e_ctrl});
      chk($sformatf("v%0d.valid", i), {31'b0, ctrl_valid}, {31'b0, vt[i].e_valid});
      chk($sformatf("v%0d.busy", i),  {31'b0, busy},       {31'b0, vt[i].e_busy});
      chk($sformatf("v%0d.done", i),  {31'b0, done},       {31'b0, vt[i].e_done});
    end
    ld_en = 1'b0; start = 1'b0; abort = 1'b0; ctrl_ready = 1'b0;
    tick();

    // Reset mid-run, then replay of the retained program.
    len = 5'd3; rep_cnt = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; ctrl_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid.ctrl",  {25'b0, ctrl},       32'd0);
    chk("rst_mid.valid", {31'b0, ctrl_valid}, 32'd0);
    chk("rst_mid.busy",  {31'b0, busy},       32'd0);
    chk("rst_mid.done",  {31'b0, done},       32'd0);
    run_collect(5'd3, 8'd1, bub);
    chk("rst_replay.n", words.size(), 32'd3);
    if (words.size() == 3) begin
      chk("rst_replay.w0", {25'b0, words[0]}, 32'h51);
      chk("rst_replay.w1", {25'b0, words[1]}, 32'h2C);
      chk("rst_replay.w2", {25'b0, words[2]}, 32'h03);
    end

    // Multi-pass replay.
    load(4'd0, 7'h0A);
    load(4'd1, 7'h0B);
`ifdef CTRL_SEQ_REPEAT_EN
    exp_n = 6;
`else
    exp_n = 2;
`endif
    run_collect(5'd2, 8'd3, bub);
    chk("rep3.n", words.size(), exp_n);
    chk("rep3.nobubble", {31'b0, bub}, 32'd0);
    for (int k = 0; k < words.size(); k++)
      chk($sformatf("rep3.w%0d", k), {25'b0, words[k]}, (k % 2) ? 32'h0B : 32'h0A);
    run_collect(5'd2, 8'd0, bub);
    chk("rep0.n", words.size(), 32'd2);

    // len above DEPTH clamps to the full store.
    for (int i = 0; i < DEPTH; i++) begin
      pat = 7'(i * 5 + 3);
      load(4'(i), pat);
    end
    run_collect(5'd20, 8'd1, bub);
    chk("len20.n", words.size(), 32'd16);
    chk("len20.nobubble", {31'b0, bub}, 32'd0);
    for (int i = 0; i < words.size(); i++) begin
      pat = 7'(i * 5 + 3);
      chk($sformatf("len20.w%0d", i), {25'b0, words[i]}, {25'b0, pat});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
